// File: rtl/matmul_pkg.sv
// Shared definitions for the 2x2 matrix multiply sequencer.
// Holds the state encoding, element/result widths, the entry index range
// and the bit offsets of the four result slots inside the packed result.
package matmul_pkg;

   localparam int ELEM_W     = 3;
   localparam int ACC_W      = 2 * ELEM_W + 1;
   localparam int PROD_W     = 2 * ELEM_W;
   localparam int ENTRY_W    = 4;
   localparam int LAST_ENTRY = 7;
   localparam int IDLE_ENTRY = 15;
   localparam int RES_W      = 4 * ACC_W;

   localparam logic [ENTRY_W-1:0] LAST_ENTRY_IDX = ENTRY_W'(LAST_ENTRY);
   localparam logic [ENTRY_W-1:0] IDLE_ENTRY_IDX = ENTRY_W'(IDLE_ENTRY);

   // Result slot offsets: C00, C01, C10, C11
   localparam int SLOT_C00 = 0 * ACC_W;
   localparam int SLOT_C01 = 1 * ACC_W;
   localparam int SLOT_C10 = 2 * ACC_W;
   localparam int SLOT_C11 = 3 * ACC_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      LAST  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Each consecutive pair of entries accumulates into one result slot.
   function automatic logic [1:0] entry_slot(input logic [ENTRY_W-1:0] entry);
      return entry[2:1];
   endfunction

endpackage

// File: rtl/matmul_pair_mac.sv
// Pair multiply-accumulate for the matrix multiply sequencer.
// Multiplies the sampled A/B elements; an even entry loads the accumulator
// with its product, an odd entry presents accumulator + product together
// with a write strobe for the result slot of that pair.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   sample_valid  the element pair on a_elem/b_elem is live this edge
//   odd_entry     the sampled entry is the second of its pair
//   a_elem,b_elem selected operands
//   pair_sum      accumulator + product, ACC_W bits
//   pair_wr       write strobe for pair_sum
module matmul_pair_mac
   import matmul_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_valid,
   input  logic              odd_entry,
   input  logic [ELEM_W-1:0] a_elem,
   input  logic [ELEM_W-1:0] b_elem,
   output logic [ACC_W-1:0]  pair_sum,
   output logic              pair_wr
);

   logic [PROD_W-1:0] product_s;
   logic [PROD_W-1:0] acc_r;

   // Unsigned product of the current operand pair
   always_comb begin
      product_s = PROD_W'(a_elem) * PROD_W'(b_elem);
   end

   // Even-entry accumulator: holds the first product of each pair
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= {PROD_W{1'b0}};
      end else if (sample_valid && !odd_entry) begin
         acc_r <= product_s;
      end else begin
         acc_r <= acc_r;
      end
   end

   // Pair sum and its write strobe; 7*7+7*7 fits in ACC_W without overflow
   always_comb begin
      pair_sum = ACC_W'(acc_r) + ACC_W'(product_s);
      pair_wr  = sample_valid & odd_entry;
   end

endmodule

// File: rtl/matmul_sequencer.sv
// Controller for the 2x2, 3-bit-element matrix multiplier.
// On start it issues entry indices 0..7 to the element selectors, samples
// each selected pair one edge later, accumulates pairs into four result
// slots, then pulses done and holds result_valid.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   start         request one multiply (only honoured in IDLE)
//   busy          operation in flight, until done drops
//   entry_out     entry index to the selectors (15 when idle)
//   a_elem,b_elem selected elements
//   result        {C11, C10, C01, C00}, 7 bits each
//   result_valid  result holds a completed product
//   done          one-cycle completion pulse
//   op_count      completed-operation counter, only present when
//                 MATMUL_SEQUENCER_OPCOUNT_EN is defined
module matmul_sequencer
   import matmul_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               busy,
   output logic [ENTRY_W-1:0] entry_out,
   input  logic [ELEM_W-1:0]  a_elem,
   input  logic [ELEM_W-1:0]  b_elem,
   output logic [RES_W-1:0]   result,
   output logic               result_valid,
   output logic               done
`ifdef MATMUL_SEQUENCER_OPCOUNT_EN
   ,
   output logic [7:0]         op_count
`endif
);

   state_t             state_r;
   state_t             state_next_s;
   logic [ENTRY_W-1:0] entry_next_s;
   logic               busy_next_s;
   logic               done_next_s;
   logic               result_valid_next_s;
   logic               issue_s;
   logic               sample_valid_r;
   logic [ACC_W-1:0]   pair_sum_s;
   logic               pair_wr_s;

   // Next-state and next-output decode
   always_comb begin
      state_next_s        = state_r;
      entry_next_s        = entry_out;
      busy_next_s         = busy;
      done_next_s         = 1'b0;
      result_valid_next_s = result_valid;
      issue_s             = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s        = ISSUE;
               entry_next_s        = {ENTRY_W{1'b0}};
               busy_next_s         = 1'b1;
               result_valid_next_s = 1'b0;
               issue_s             = 1'b1;
            end else begin
               state_next_s = IDLE;
            end
         end
         ISSUE: begin
            // Issuing LAST_ENTRY moves to LAST so entry_out never passes 7
            entry_next_s = entry_out + 4'd1;
            issue_s      = 1'b1;
            if (entry_out == (LAST_ENTRY_IDX - 4'd1)) begin
               state_next_s = LAST;
            end else begin
               state_next_s = ISSUE;
            end
         end
         LAST: begin
            // Entry 7 is sampled on this edge, completing C11
            entry_next_s        = IDLE_ENTRY_IDX;
            done_next_s         = 1'b1;
            result_valid_next_s = 1'b1;
            state_next_s        = DONE;
         end
         DONE: begin
            busy_next_s  = 1'b0;
            state_next_s = IDLE;
         end
         default: begin
            state_next_s        = IDLE;
            entry_next_s        = IDLE_ENTRY_IDX;
            busy_next_s         = 1'b0;
            result_valid_next_s = 1'b0;
         end
      endcase
   end

   // State and registered control outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= IDLE;
         entry_out      <= IDLE_ENTRY_IDX;
         busy           <= 1'b0;
         done           <= 1'b0;
         result_valid   <= 1'b0;
         sample_valid_r <= 1'b0;
      end else begin
         state_r        <= state_next_s;
         entry_out      <= entry_next_s;
         busy           <= busy_next_s;
         done           <= done_next_s;
         result_valid   <= result_valid_next_s;
         // Index issued on this edge is sampled on the next one
         sample_valid_r <= issue_s;
      end
   end

   matmul_pair_mac u_mac (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_valid (sample_valid_r),
      .odd_entry    (entry_out[0]),
      .a_elem       (a_elem),
      .b_elem       (b_elem),
      .pair_sum     (pair_sum_s),
      .pair_wr      (pair_wr_s)
   );

   // Result slots, written as each pair completes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= {RES_W{1'b0}};
      end else if (pair_wr_s) begin
         case (entry_slot(entry_out))
            2'd0:    result[SLOT_C00 +: ACC_W] <= pair_sum_s;
            2'd1:    result[SLOT_C01 +: ACC_W] <= pair_sum_s;
            2'd2:    result[SLOT_C10 +: ACC_W] <= pair_sum_s;
            2'd3:    result[SLOT_C11 +: ACC_W] <= pair_sum_s;
            default: result <= result;
         endcase
      end else begin
         result <= result;
      end
   end

`ifdef MATMUL_SEQUENCER_OPCOUNT_EN
   // Completed-operation counter, bumped on the edge that raises done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= 8'd0;
      end else if (state_r == LAST) begin
         op_count <= op_count + 8'd1;
      end else begin
         op_count <= op_count;
      end
   end
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a negedge selector model.
module tb_matmul_sequencer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        busy;
   logic [3:0]  entry_out;
   logic [2:0]  a_elem;
   logic [2:0]  b_elem;
   logic [27:0] result;
   logic        result_valid;
   logic        done;
`ifdef MATMUL_SEQUENCER_OPCOUNT_EN
   logic [7:0]  op_count;
`endif

   int checks = 0;
   int errors = 0;

   // A indexed {i,k}, B indexed {k,j}
   logic [2:0] mat_a [4];
   logic [2:0] mat_b [4];

   matmul_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .busy         (busy),
      .entry_out    (entry_out),
      .a_elem       (a_elem),
      .b_elem       (b_elem),
      .result       (result),
      .result_valid (result_valid),
      .done         (done)
`ifdef MATMUL_SEQUENCER_OPCOUNT_EN
      ,
      .op_count     (op_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] sel_a(input logic [3:0] e);
      logic [1:0] idx;
      if (e > 4'd7) return 3'd0;
      idx = {e[2], e[0]};
      return mat_a[idx];
   endfunction

   function automatic logic [2:0] sel_b(input logic [3:0] e);
      logic [1:0] idx;
      if (e > 4'd7) return 3'd0;
      idx = {e[0], e[1]};
      return mat_b[idx];
   endfunction

   // Element selectors update on the falling edge
   always @(negedge clk) begin
      a_elem = sel_a(entry_out);
      b_elem = sel_b(entry_out);
   end

   function automatic logic [27:0] calc_result();
      logic [27:0] r;
      logic [6:0]  c;
      r = 28'd0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            c = 7'd0;
            for (int k = 0; k < 2; k++)
               c = c + 7'(mat_a[i*2+k]) * 7'(mat_b[k*2+j]);
            r[(i*2+j)*7 +: 7] = c;
         end
      end
      return r;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [2:0] a00, a01, a10, a11, b00, b01, b10, b11);
      mat_a[0] = a00; mat_a[1] = a01; mat_a[2] = a10; mat_a[3] = a11;
      mat_b[0] = b00; mat_b[1] = b01; mat_b[2] = b10; mat_b[3] = b11;
   endtask

   // One full operation from the accepting edge through the idle edge after DONE
   task automatic run_op(input string tag, input logic [27:0] exp_res, input bit poke);
      int done_seen;
      done_seen = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      check_eq({tag, "_busy_p0"}, busy, 1);
      check_eq({tag, "_entry_p0"}, entry_out, 0);
      check_eq({tag, "_rv_p0"}, result_valid, 0);
      for (int c = 1; c <= 7; c++) begin
         start = (poke && c == 3) ? 1'b1 : 1'b0;
         step();
         check_eq($sformatf("%s_entry_p%0d", tag, c), entry_out, c);
         done_seen += int'(done);
      end
      start = 1'b0;
      step();
      done_seen += int'(done);
      check_eq({tag, "_done_p8"}, done, 1);
      check_eq({tag, "_rv_p8"}, result_valid, 1);
      check_eq({tag, "_busy_p8"}, busy, 1);
      check_eq({tag, "_entry_p8"}, entry_out, 15);
      check_eq({tag, "_result"}, result, exp_res);
      step();
      done_seen += int'(done);
      check_eq({tag, "_done_p9"}, done, 0);
      check_eq({tag, "_busy_p9"}, busy, 0);
      check_eq({tag, "_rv_p9"}, result_valid, 1);
      step();
      done_seen += int'(done);
      check_eq({tag, "_busy_p10"}, busy, 0);
      check_eq({tag, "_entry_p10"}, entry_out, 15);
      check_eq({tag, "_done_count"}, done_seen, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a_elem = 3'd0;
      b_elem = 3'd0;
      load(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
      repeat (3) step();
      check_eq("rst_entry", entry_out, 15);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_rv", result_valid, 0);
      check_eq("rst_result", result, 0);
`ifdef MATMUL_SEQUENCER_OPCOUNT_EN
      check_eq("rst_opcount", op_count, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // A=[[1,2],[3,4]] B=[[5,6],[7,0]] -> C00=19 C01=6 C10=43 C11=18
      load(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0);
      run_op("basic", {7'd18, 7'd43, 7'd6, 7'd19}, 1'b0);

      // All sevens -> every slot 98
      load(3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7);
      run_op("max", {7'd98, 7'd98, 7'd98, 7'd98}, 1'b0);

      // Start pulsed mid-operation must be ignored
      load(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0);
      run_op("poke", {7'd18, 7'd43, 7'd6, 7'd19}, 1'b1);

      // Start held high: a new operation every 10 cycles
      load(3'd2, 3'd3, 3'd1, 3'd5, 3'd4, 3'd1, 3'd6, 3'd2);
      start = 1'b1;
      for (int cyc = 0; cyc < 30; cyc++) begin
         step();
         if (cyc == 29) start = 1'b0;
         check_eq($sformatf("hold_done_c%0d", cyc), done, ((cyc % 10) == 8) ? 1 : 0);
         check_eq($sformatf("hold_rv_c%0d", cyc), result_valid, ((cyc % 10) >= 8) ? 1 : 0);
         check_eq($sformatf("hold_busy_c%0d", cyc), busy, ((cyc % 10) != 9) ? 1 : 0);
         check_eq($sformatf("hold_entry_c%0d", cyc), entry_out, ((cyc % 10) <= 7) ? (cyc % 10) : 15);
         if ((cyc % 10) == 8) check_eq($sformatf("hold_result_c%0d", cyc), result, calc_result());
      end
      step();
      check_eq("hold_release_busy", busy, 0);

      // Reset while entry_out is 4: abort without done
      load(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      check_eq("abort_entry_pre", entry_out, 4);
      rst_n = 1'b0;
      #1;
      check_eq("abort_entry", entry_out, 15);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_result", result, 0);
      check_eq("abort_rv", result_valid, 0);
      for (int c = 0; c < 4; c++) begin
         step();
         check_eq($sformatf("abort_done_%0d", c), done, 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      // A=[[7,0],[5,3]] B=[[2,6],[4,1]] -> C00=14 C01=42 C10=22 C11=33
      load(3'd7, 3'd0, 3'd5, 3'd3, 3'd2, 3'd6, 3'd4, 3'd1);
      run_op("after_abort", {7'd33, 7'd22, 7'd42, 7'd14}, 1'b0);

`ifdef MATMUL_SEQUENCER_OPCOUNT_EN
      begin
         int ops;
         ops = 0;
         rst_n = 1'b0;
         step();
         check_eq("opcnt_rst", op_count, 0);
         @(negedge clk);
         rst_n = 1'b1;
         start = 1'b1;
         for (int c = 0; c < 3000 && ops < 257; c++) begin
            step();
            ops += int'(done);
            if (ops >= 257) start = 1'b0;
         end
         start = 1'b0;
         check_eq("opcnt_ops", ops, 257);
         check_eq("opcnt_wrap", op_count, 1);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
